led_temporal_filter: RTL and testbench

// - Per-zone temporal IIR smoothing between block_360_pro (zone-brightness producer) and MiniLED_driver (consumer).
// - On each frame strobe: walk all NZONE zones, one per clock; move each held level toward the new zone value by diff>>>SHIFT.
// - Fast-attack when |diff| > CUT_THR (scene cut): jump straight to the new value.
// - Removes backlight flicker on noisy video; scene cuts still respond within one frame.

---
 rtl/led_temporal_filter_pkg.sv | 30 +++
 rtl/led_iir_step.sv | 49 ++++
 rtl/led_temporal_filter.sv | 119 +++++++++++
 tb/tb_led_temporal_filter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_temporal_filter_pkg.sv
// ---------------------------------------------------------------------------
// led_temporal_filter_pkg
// Shared constants and types for the per-zone LED temporal filter.
// The zone count and zone width match the zone-brightness producer and the
// MiniLED driver, so all three blocks agree on the flattened bus layout.
// ---------------------------------------------------------------------------
package led_temporal_filter_pkg;

  localparam int NZONE   = 360;               // number of LED zones
  localparam int DW      = 8;                 // bits per zone brightness
  localparam int SHIFT   = 2;                 // IIR shift, alpha = 1/2^SHIFT
  localparam int CUT_THR = 64;                // |diff| above this is a scene cut
  localparam int CW      = $clog2(NZONE);     // zone counter width
  localparam int LW      = NZONE * DW;        // flattened bus width
  localparam int BW      = $clog2(LW);        // bit-offset width into the bus

  localparam logic [CW-1:0] LAST_ZONE = CW'(NZONE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit offset of zone 'zone' inside the flattened bus.
  function automatic logic [BW-1:0] zone_base(input logic [CW-1:0] zone);
    zone_base = BW'(zone) * BW'(DW);
  endfunction

endpackage

// File: rtl/led_iir_step.sv
// ---------------------------------------------------------------------------
// led_iir_step
// Combinational single-zone IIR update.
//   x       : new zone value from upstream
//   y       : currently held (filtered) zone level
//   filt_en : 1 = smooth, 0 = bypass (y_new = x)
//   y_new   : next held level
// A large jump (|x-y| > CUT_THR) is treated as a scene cut and loads x
// directly. Otherwise y moves by (x-y)>>>SHIFT, forced to at least one LSB
// so the level always reaches x exactly. The result cannot leave 0..2^DW-1
// because the step never exceeds the difference, so no saturation is needed.
// ---------------------------------------------------------------------------
module led_iir_step #(
  parameter int DW      = 8,
  parameter int SHIFT   = 2,
  parameter int CUT_THR = 64
) (
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  input  logic          filt_en,
  output logic [DW-1:0] y_new
);

  logic signed [DW:0] w_diff;
  logic signed [DW:0] w_shr;
  logic        [DW:0] w_mag;
  logic        [DW-1:0] w_step;

  // Difference, magnitude, shifted step and final level selection.
  always_comb begin
    w_diff = $signed({1'b0, x}) - $signed({1'b0, y});
    w_mag  = w_diff[DW] ? $unsigned(-w_diff) : $unsigned(w_diff);
    w_shr  = w_diff >>> SHIFT;

    // Tiny differences shift to zero; nudge by one LSB toward x instead.
    if ((w_shr == {(DW+1){1'b0}}) && (w_diff != {(DW+1){1'b0}})) begin
      w_step = w_diff[DW] ? {DW{1'b1}} : {{(DW-1){1'b0}}, 1'b1};
    end else begin
      w_step = w_shr[DW-1:0];
    end

    if (!filt_en || (w_mag > (DW+1)'(CUT_THR))) begin
      y_new = x;
    end else begin
      y_new = y + w_step;
    end
  end

endmodule

// File: rtl/led_temporal_filter.sv
// ---------------------------------------------------------------------------
// led_temporal_filter
// Per-zone temporal IIR smoothing of LED backlight levels. Each frame strobe
// starts a scan that updates one zone per clock through a single shared
// led_iir_step instance.
// Ports:
//   I_clk        system clock
//   I_rst_n      asynchronous active-low reset
//   I_frame_stb  1-cycle pulse: new zone set valid on I_led_light
//   I_filt_en    1 = IIR smoothing, 0 = bypass; sampled per zone
//   I_led_light  flattened new zone values, zone k at [k*DW +: DW]
//   O_led_light  flattened filtered levels (registered)
//   O_busy       high while zones are being written
//   O_done       1-cycle pulse in the cycle after the last zone write
// A strobe arriving during a scan (or in its DONE cycle) is remembered in a
// single pending flag and starts exactly one more scan; further strobes are
// dropped.
// ---------------------------------------------------------------------------
module led_temporal_filter
  import led_temporal_filter_pkg::*;
(
  input  logic          I_clk,
  input  logic          I_rst_n,
  input  logic          I_frame_stb,
  input  logic          I_filt_en,
  input  logic [LW-1:0] I_led_light,
  output logic [LW-1:0] O_led_light,
  output logic          O_busy,
  output logic          O_done
);

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_pending;
  logic            r_busy;
  logic            r_done;
  logic [LW-1:0]   r_led;

  logic [BW-1:0]   w_base;
  logic [DW-1:0]   w_x;
  logic [DW-1:0]   w_y;
  logic [DW-1:0]   w_y_new;

  // Zone mux: select the current zone's new value and held level.
  assign w_base = zone_base(r_cnt);
  assign w_x    = I_led_light[w_base +: DW];
  assign w_y    = r_led[w_base +: DW];

  led_iir_step #(
    .DW      (DW),
    .SHIFT   (SHIFT),
    .CUT_THR (CUT_THR)
  ) u_step (
    .x       (w_x),
    .y       (w_y),
    .filt_en (I_filt_en),
    .y_new   (w_y_new)
  );

  // Scan FSM, zone counter, pending flag, zone registers and status outputs.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= {CW{1'b0}};
      r_pending <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_led     <= {LW{1'b0}};
    end else begin
      // Status lags the state by one cycle so busy covers exactly the
      // write edges and done lands one cycle after the last write.
      r_busy <= (r_state == ST_SCAN);
      r_done <= (r_state == ST_DONE);

      case (r_state)
        ST_IDLE: begin
          if (I_frame_stb) begin
            r_state <= ST_SCAN;
            r_cnt   <= {CW{1'b0}};
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          r_led[w_base +: DW] <= w_y_new;
          if (I_frame_stb) begin
            r_pending <= 1'b1;
          end
          if (r_cnt == LAST_ZONE) begin
            r_state <= ST_DONE;
            r_cnt   <= {CW{1'b0}};
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          // A strobe in this very cycle counts as pending too.
          if (r_pending || I_frame_stb) begin
            r_state   <= ST_SCAN;
            r_cnt     <= {CW{1'b0}};
            r_pending <= 1'b0;
          end else begin
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= {CW{1'b0}};
          r_pending <= 1'b0;
        end
      endcase
    end
  end

  assign O_led_light = r_led;
  assign O_busy      = r_busy;
  assign O_done      = r_done;

endmodule

// File: tb/tb_led_temporal_filter.sv
module tb_led_temporal_filter;
  import led_temporal_filter_pkg::*;

  logic          I_clk;
  logic          I_rst_n;
  logic          I_frame_stb;
  logic          I_filt_en;
  logic [LW-1:0] I_led_light;
  logic [LW-1:0] O_led_light;
  logic          O_busy;
  logic          O_done;

  int total;
  int bad;
  int model [NZONE];   // expected held level per zone
  int tb_x  [NZONE];   // new zone values for the next frame

  led_temporal_filter dut (
    .I_clk       (I_clk),
    .I_rst_n     (I_rst_n),
    .I_frame_stb (I_frame_stb),
    .I_filt_en   (I_filt_en),
    .I_led_light (I_led_light),
    .O_led_light (O_led_light),
    .O_busy      (O_busy),
    .O_done      (O_done)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  // Reference rule: arithmetic on integers, floor division for the shift.
  function automatic int iir_ref(input int x, input int y, input bit en);
    int d;
    int s;
    d = x - y;
    if (!en || d > CUT_THR || d < -CUT_THR) return x;
    if (d >= 0) s = d / (1 << SHIFT);
    else        s = -((-d + (1 << SHIFT) - 1) / (1 << SHIFT));
    if (s == 0 && d != 0) s = (d > 0) ? 1 : -1;
    return y + s;
  endfunction

  function automatic int get_zone(input int k);
    logic [LW-1:0] t;
    t = O_led_light >> (k * DW);
    return int'(t[DW-1:0]);
  endfunction

  function automatic logic [LW-1:0] pack_arr(input int a [NZONE]);
    logic [LW-1:0] v;
    logic [DW-1:0] z;
    v = '0;
    for (int k = 0; k < NZONE; k++) begin
      z = DW'(a[k]);
      v = v | (LW'(z) << (k * DW));
    end
    return v;
  endfunction

  function automatic int clamp8(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic set_all_x(input int v);
    for (int k = 0; k < NZONE; k++) tb_x[k] = v;
  endtask

  task automatic strobe();
    @(posedge I_clk); #1;
    I_frame_stb = 1'b1;
    @(posedge I_clk); #1;
    I_frame_stb = 1'b0;
  endtask

  // One full scan with per-zone timing checks; zones >= split use en_hi.
  task automatic do_scan(input bit en_lo, input bit en_hi, input int split, input string tag);
    int exp_new [NZONE];
    I_led_light = pack_arr(tb_x);
    for (int k = 0; k < NZONE; k++)
      exp_new[k] = iir_ref(tb_x[k], model[k], (k >= split) ? en_hi : en_lo);
    I_filt_en = (split <= 0) ? en_hi : en_lo;
    strobe();
    total++;
    if (O_busy !== 1'b0) begin
      bad++; $display("FAIL %s busy_at_strobe got=%0b exp=0", tag, O_busy);
    end
    for (int k = 0; k < NZONE; k++) begin
      I_filt_en = (k >= split) ? en_hi : en_lo;
      @(posedge I_clk); #1;
      total++;
      if (get_zone(k) !== exp_new[k]) begin
        bad++; $display("FAIL %s zone%0d got=%0d exp=%0d", tag, k, get_zone(k), exp_new[k]);
      end
      if (k + 1 < NZONE) begin
        total++;
        if (get_zone(k + 1) !== model[k + 1]) begin
          bad++; $display("FAIL %s early_zone%0d got=%0d exp=%0d", tag, k + 1, get_zone(k + 1), model[k + 1]);
        end
      end
      total++;
      if ({O_busy, O_done} !== 2'b10) begin
        bad++; $display("FAIL %s busy_done_zone%0d got=%b exp=10", tag, k, {O_busy, O_done});
      end
    end
    @(posedge I_clk); #1;
    total++;
    if ({O_busy, O_done} !== 2'b01) begin
      bad++; $display("FAIL %s done_pulse got=%b exp=01", tag, {O_busy, O_done});
    end
    @(posedge I_clk); #1;
    total++;
    if ({O_busy, O_done} !== 2'b00) begin
      bad++; $display("FAIL %s done_end got=%b exp=00", tag, {O_busy, O_done});
    end
    model = exp_new;
  endtask

  task automatic check_all(input int v, input string tag);
    for (int k = 0; k < NZONE; k++) begin
      total++;
      if (get_zone(k) !== v) begin
        bad++; $display("FAIL %s zone%0d got=%0d exp=%0d", tag, k, get_zone(k), v);
      end
    end
  endtask

  task automatic test_reset();
    I_rst_n = 1'b0;
    repeat (3) @(posedge I_clk);
    #1;
    total++;
    if ({O_led_light, O_busy, O_done} !== {(LW+2){1'b0}}) begin
      bad++; $display("FAIL reset_values busy=%0b done=%0b nonzero_out=%0b exp=0", O_busy, O_done, |O_led_light);
    end
    I_rst_n = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(posedge I_clk); #1;
      total++;
      if ({O_busy, O_done} !== 2'b00 || O_led_light !== {LW{1'b0}}) begin
        bad++; $display("FAIL idle_quiet cycle%0d busy=%0b done=%0b exp=0", c, O_busy, O_done);
      end
    end
    for (int k = 0; k < NZONE; k++) model[k] = 0;
  endtask

  task automatic test_convergence();
    set_all_x(200);
    do_scan(1'b1, 1'b1, 0, "conv_cut");
    check_all(200, "conv_cut_const");
    set_all_x(180);
    do_scan(1'b1, 1'b1, 0, "conv_step1");
    check_all(195, "conv_195_const");
    for (int f = 0; f < 9; f++) do_scan(1'b1, 1'b1, 0, "conv_iter");
    check_all(180, "conv_settle_const");
  endtask

  task automatic test_small_step();
    set_all_x(100);
    do_scan(1'b0, 1'b0, 0, "small_load");
    set_all_x(102);
    do_scan(1'b1, 1'b1, 0, "small_up1");
    check_all(101, "small_101_const");
    do_scan(1'b1, 1'b1, 0, "small_up2");
    check_all(102, "small_102_const");
    set_all_x(100);
    do_scan(1'b0, 1'b0, 0, "small_reload");
    set_all_x(98);
    do_scan(1'b1, 1'b1, 0, "small_dn1");
    check_all(99, "small_99_const");
    do_scan(1'b1, 1'b1, 0, "small_dn2");
    check_all(98, "small_98_const");
  endtask

  task automatic test_bypass();
    int base [NZONE];
    set_all_x(10);
    do_scan(1'b0, 1'b0, 0, "byp_load");
    set_all_x(250);
    do_scan(1'b0, 1'b0, 0, "byp_jump");
    check_all(250, "byp_250_const");
    for (int k = 0; k < NZONE; k++) tb_x[k] = $urandom_range(0, 200);
    do_scan(1'b0, 1'b0, 0, "byp_rand");
    for (int k = 0; k < NZONE; k++) begin
      base[k] = tb_x[k];
      tb_x[k] = base[k] + 30;
    end
    do_scan(1'b0, 1'b1, 100, "byp_toggle");
    total++;
    if (get_zone(99) !== base[99] + 30) begin
      bad++; $display("FAIL toggle_zone99 got=%0d exp=%0d", get_zone(99), base[99] + 30);
    end
    total++;
    if (get_zone(100) !== base[100] + 7) begin
      bad++; $display("FAIL toggle_zone100 got=%0d exp=%0d", get_zone(100), base[100] + 7);
    end
  endtask

  task automatic test_random();
    bit en;
    for (int f = 0; f < 5; f++) begin
      en = 1'($urandom_range(0, 3) != 0);
      for (int k = 0; k < NZONE; k++)
        tb_x[k] = clamp8(model[k] + $urandom_range(0, 180) - 90);
      do_scan(en, en, 0, "random");
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    int exp2 [NZONE];
    for (int k = 0; k < NZONE; k++) begin
      tb_x[k] = $urandom_range(0, 255);
      exp2[k] = iir_ref(tb_x[k], iir_ref(tb_x[k], model[k], 1'b1), 1'b1);
    end
    I_led_light = pack_arr(tb_x);
    I_filt_en = 1'b1;
    strobe();
    dones = 0;
    for (int c = 1; c <= 1200; c++) begin
      I_frame_stb = (c == 50 || c == 120) ? 1'b1 : 1'b0;
      @(posedge I_clk); #1;
      if (O_done === 1'b1) dones++;
    end
    I_frame_stb = 1'b0;
    total++;
    if (dones !== 2) begin
      bad++; $display("FAIL pending_done_count got=%0d exp=2", dones);
    end
    total++;
    if (O_led_light !== pack_arr(exp2)) begin
      bad++; $display("FAIL pending_final zone0 got=%0d exp=%0d", get_zone(0), exp2[0]);
    end
    model = exp2;

    // Strobe landing in the DONE cycle starts the next scan immediately.
    for (int k = 0; k < NZONE; k++) begin
      tb_x[k] = $urandom_range(0, 255);
      exp2[k] = iir_ref(tb_x[k], iir_ref(tb_x[k], model[k], 1'b1), 1'b1);
    end
    I_led_light = pack_arr(tb_x);
    strobe();
    repeat (NZONE) @(posedge I_clk);
    #1;
    I_frame_stb = 1'b1;
    @(posedge I_clk); #1;
    I_frame_stb = 1'b0;
    total++;
    if ({O_busy, O_done} !== 2'b01) begin
      bad++; $display("FAIL done_cycle_stb_pulse got=%b exp=01", {O_busy, O_done});
    end
    @(posedge I_clk); #1;
    total++;
    if (O_busy !== 1'b1 || get_zone(0) !== exp2[0]) begin
      bad++; $display("FAIL done_cycle_restart busy=%0b zone0=%0d exp busy=1 zone0=%0d", O_busy, get_zone(0), exp2[0]);
    end
    dones = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge I_clk); #1;
      if (O_done === 1'b1) dones++;
    end
    total++;
    if (dones !== 1 || O_busy !== 1'b0) begin
      bad++; $display("FAIL done_cycle_second_scan dones=%0d busy=%0b exp dones=1 busy=0", dones, O_busy);
    end
    total++;
    if (O_led_light !== pack_arr(exp2)) begin
      bad++; $display("FAIL done_cycle_final zone359 got=%0d exp=%0d", get_zone(NZONE - 1), exp2[NZONE - 1]);
    end
    model = exp2;
  endtask

  task automatic test_reset_mid();
    int busy_seen;
    for (int k = 0; k < NZONE; k++) tb_x[k] = $urandom_range(1, 255);
    I_led_light = pack_arr(tb_x);
    I_filt_en = 1'b0;
    strobe();
    for (int k = 0; k <= 150; k++) begin
      I_frame_stb = (k == 20) ? 1'b1 : 1'b0;
      @(posedge I_clk); #1;
    end
    I_frame_stb = 1'b0;
    total++;
    if (get_zone(150) !== tb_x[150]) begin
      bad++; $display("FAIL midreset_pre zone150 got=%0d exp=%0d", get_zone(150), tb_x[150]);
    end
    #2;
    I_rst_n = 1'b0;
    #1;
    total++;
    if ({O_led_light, O_busy, O_done} !== {(LW+2){1'b0}}) begin
      bad++; $display("FAIL midreset_clear busy=%0b done=%0b nonzero_out=%0b exp=0", O_busy, O_done, |O_led_light);
    end
    @(posedge I_clk); #1;
    I_rst_n = 1'b1;
    busy_seen = 0;
    for (int c = 0; c < 500; c++) begin
      @(posedge I_clk); #1;
      if (O_busy !== 1'b0 || O_done !== 1'b0) busy_seen++;
    end
    total++;
    if (busy_seen !== 0 || O_led_light !== {LW{1'b0}}) begin
      bad++; $display("FAIL midreset_idle active_cycles=%0d exp=0", busy_seen);
    end
    for (int k = 0; k < NZONE; k++) model[k] = 0;
    set_all_x(77);
    do_scan(1'b1, 1'b1, 0, "post_reset");
    check_all(77, "post_reset_const");
  endtask

  initial begin
    total = 0;
    bad = 0;
    I_rst_n = 1'b0;
    I_frame_stb = 1'b0;
    I_filt_en = 1'b0;
    I_led_light = '0;
    test_reset();
    test_convergence();
    test_small_step();
    test_bypass();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
